// File: rtl/alsaqr_credit_to_valrdy_mc.sv
// Buffers NUM_CH credit-based flit channels and merges them onto one val/rdy port via round-robin; each pop returns a yummy.
// Optional ALSAQR_CTV_OVF_DETECT_EN adds sticky overflow reporting on ovf_err/ovf_ch.
module alsaqr_credit_to_valrdy_mc #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 3,
    parameter int DEPTH      = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            valid_in,
    output logic [NUM_CH-1:0]            yummy_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [CH_W-1:0]              ch_out
`ifdef ALSAQR_CTV_OVF_DETECT_EN
    ,
    output logic                         ovf_err,
    output logic [CH_W-1:0]              ovf_ch
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0] CH_ONE   = CH_W'(1);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [DATA_WIDTH-1:0] mem  [NUM_CH][DEPTH];
    logic [AW-1:0]         wptr [NUM_CH];
    logic [AW-1:0]         rptr [NUM_CH];
    logic [AW:0]           cnt  [NUM_CH];

    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    state_t          state_q, state_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;
    logic [CH_W-1:0] rr_q;
    logic [CH_W-1:0] scan_grant;
    logic [CH_W-1:0] grant;
    logic            handshake;

    always_comb begin
        nonempty = '0;
        full     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nonempty[c] = (cnt[c] != '0);
            full[c]     = (cnt[c] == FULL_CNT);
        end
    end

    // A full FIFO still accepts a flit when its head leaves on the same edge.
    always_comb begin
        push = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            push[c] = valid_in[c] & (~full[c] | pop[c]);
        end
    end

    assign valid_out = |nonempty;
    assign handshake = valid_out & ready_out;
    assign pop       = handshake ? (NUM_CH'(1) << grant) : '0;
    assign data_out  = valid_out ? mem[grant][rptr[grant]] : '0;
    assign ch_out    = valid_out ? grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wptr[c] <= wptr[c] + PTR_ONE;
                if (pop[c])  rptr[c] <= rptr[c] + PTR_ONE;
                if (push[c] && !pop[c])      cnt[c] <= cnt[c] + CNT_ONE;
                else if (!push[c] && pop[c]) cnt[c] <= cnt[c] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) mem[c][wptr[c]] <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First non-empty channel at or after the round-robin pointer.
    always_comb begin
        logic            found;
        int              idx;
        logic [CH_W-1:0] idx_c;
        found      = 1'b0;
        idx        = 0;
        idx_c      = '0;
        scan_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx_c = CH_W'(idx);
            if (!found && nonempty[idx_c]) begin
                found      = 1'b1;
                scan_grant = idx_c;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        grant     = scan_grant;
        case (state_q)
            IDLE: begin
                if (valid_out && !ready_out) begin
                    state_d   = HOLD;
                    lock_ch_d = scan_grant;
                end
            end
            HOLD: begin
                grant = lock_ch_q;
                if (ready_out) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            rr_q      <= '0;
            yummy_out <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            yummy_out <= pop;
            if (handshake) rr_q <= (grant == LAST_CH) ? '0 : grant + CH_ONE;
        end
    end

`ifdef ALSAQR_CTV_OVF_DETECT_EN
    logic [NUM_CH-1:0] ovf_hit;
    logic [CH_W-1:0]   ovf_low;

    // Descending scan so the lowest overflowing channel wins.
    always_comb begin
        ovf_hit = '0;
        ovf_low = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            ovf_hit[c] = valid_in[c] & full[c] & ~pop[c];
            if (ovf_hit[c]) ovf_low = CH_W'(c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
            ovf_ch  <= '0;
        end else if (!ovf_err && (|ovf_hit)) begin
            ovf_err <= 1'b1;
            ovf_ch  <= ovf_low;
        end
    end
`endif

endmodule

// File: tb/tb_alsaqr_credit_to_valrdy_mc.sv
// Directed bench for alsaqr_credit_to_valrdy_mc (NUM_CH=3, DATA_WIDTH=64, DEPTH=4).
module tb_alsaqr_credit_to_valrdy_mc;
    localparam int DW = 64;
    localparam int NC = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NC*DW-1:0] data_in = '0;
    logic [NC-1:0]   valid_in = '0;
    logic [NC-1:0]   yummy_out;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic            ready_out = 1'b0;
    logic [1:0]      ch_out;
`ifdef ALSAQR_CTV_OVF_DETECT_EN
    logic            ovf_err;
    logic [1:0]      ovf_ch;
`endif

    int checks = 0;
    int failures = 0;

    alsaqr_credit_to_valrdy_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .valid_in(valid_in),
        .yummy_out(yummy_out),
        .data_out(data_out),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .ch_out(ch_out)
`ifdef ALSAQR_CTV_OVF_DETECT_EN
        ,
        .ovf_err(ovf_err),
        .ovf_ch(ovf_ch)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(int c, int k);
        return 64'hA5A5_0000_0000_0000 | (64'(c) << 8) | 64'(k);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        valid_in = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", valid_out); end
        checks++; if (yummy_out !== 3'b000) begin failures++; $display("FAIL reset_yummy got %b exp 000", yummy_out); end
        checks++; if (ch_out !== 2'd0) begin failures++; $display("FAIL reset_ch got %0d exp 0", ch_out); end
        checks++; if (data_out !== 64'h0) begin failures++; $display("FAIL reset_data got %h exp 0", data_out); end
`ifdef ALSAQR_CTV_OVF_DETECT_EN
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b exp 0", ovf_err); end
`endif
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_single();
        ready_out = 1'b1;
        valid_in = 3'b001;
        data_in[0 +: DW] = 64'h800000008084c008;
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL single_nobypass got %b exp 0", valid_out); end
        cyc();
        valid_in = '0;
        @(negedge clk);
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL single_valid got %b exp 1", valid_out); end
        checks++; if (data_out !== 64'h800000008084c008) begin failures++; $display("FAIL single_data got %h exp 800000008084c008", data_out); end
        checks++; if (ch_out !== 2'd0) begin failures++; $display("FAIL single_ch got %0d exp 0", ch_out); end
        checks++; if (yummy_out !== 3'b000) begin failures++; $display("FAIL single_yummy_early got %b exp 000", yummy_out); end
        cyc();
        @(negedge clk);
        checks++; if (yummy_out !== 3'b001) begin failures++; $display("FAIL single_yummy got %b exp 001", yummy_out); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL single_drained got %b exp 0", valid_out); end
        cyc();
        @(negedge clk);
        checks++; if (yummy_out !== 3'b000) begin failures++; $display("FAIL single_yummy_once got %b exp 000", yummy_out); end
        cyc();
    endtask

    // Round-robin pointer sits at 1 here, so ch1 is granted before ch0 arrives.
    task automatic test_backpressure();
        ready_out = 1'b0;
        valid_in = 3'b010;
        data_in[DW +: DW] = 64'h00fff10100000300;
        cyc();
        valid_in = 3'b001;
        data_in[0 +: DW] = 64'h1;
        @(negedge clk);
        checks++; if (ch_out !== 2'd1) begin failures++; $display("FAIL bp_first_ch got %0d exp 1", ch_out); end
        cyc();
        valid_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (valid_out !== 1'b1 || ch_out !== 2'd1 || data_out !== 64'h00fff10100000300) begin
                failures++; $display("FAIL bp_hold%0d got v=%b ch=%0d d=%h exp v=1 ch=1 d=00fff10100000300", i, valid_out, ch_out, data_out);
            end
            checks++; if (yummy_out !== 3'b000) begin failures++; $display("FAIL bp_hold_yummy%0d got %b exp 000", i, yummy_out); end
            cyc();
        end
        ready_out = 1'b1;
        cyc();
        @(negedge clk);
        checks++; if (yummy_out !== 3'b010) begin failures++; $display("FAIL bp_yummy1 got %b exp 010", yummy_out); end
        checks++; if (valid_out !== 1'b1 || ch_out !== 2'd0 || data_out !== 64'h1) begin
            failures++; $display("FAIL bp_second got v=%b ch=%0d d=%h exp v=1 ch=0 d=1", valid_out, ch_out, data_out);
        end
        cyc();
        @(negedge clk);
        checks++; if (yummy_out !== 3'b001) begin failures++; $display("FAIL bp_yummy0 got %b exp 001", yummy_out); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL bp_drained got %b exp 0", valid_out); end
        cyc();
    endtask

    task automatic test_round_robin();
        do_reset();
        ready_out = 1'b0;
        for (int k = 0; k < 4; k++) begin
            valid_in = 3'b111;
            for (int c = 0; c < NC; c++) data_in[c*DW +: DW] = pat(c, k);
            cyc();
        end
        valid_in = '0;
        ready_out = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (valid_out !== 1'b1 || ch_out !== 2'(i % 3) || data_out !== pat(i % 3, i / 3)) begin
                failures++; $display("FAIL rr_grant%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", i, valid_out, ch_out, data_out, i % 3, pat(i % 3, i / 3));
            end
            if (i > 0) begin
                checks++; if (yummy_out !== (3'b001 << ((i - 1) % 3))) begin
                    failures++; $display("FAIL rr_yummy%0d got %b exp %b", i, yummy_out, 3'b001 << ((i - 1) % 3));
                end
            end
            cyc();
        end
        @(negedge clk);
        checks++; if (yummy_out !== 3'b100) begin failures++; $display("FAIL rr_last_yummy got %b exp 100", yummy_out); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rr_drained got %b exp 0", valid_out); end
        cyc();
    endtask

    task automatic test_full_boundary();
        ready_out = 1'b0;
        valid_in = 3'b100;
        for (int k = 0; k < 4; k++) begin
            data_in[2*DW +: DW] = pat(2, 16 + k);
            cyc();
        end
        data_in[2*DW +: DW] = pat(2, 20);
        ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (valid_out !== 1'b1 || ch_out !== 2'd2 || data_out !== pat(2, 16 + i)) begin
                failures++; $display("FAIL full_flit%0d got v=%b ch=%0d d=%h exp v=1 ch=2 d=%h", i, valid_out, ch_out, data_out, pat(2, 16 + i));
            end
            checks++; if (yummy_out !== ((i == 0) ? 3'b000 : 3'b100)) begin
                failures++; $display("FAIL full_yummy%0d got %b exp %b", i, yummy_out, (i == 0) ? 3'b000 : 3'b100);
            end
            cyc();
            valid_in = '0;
        end
        @(negedge clk);
        checks++; if (valid_out !== 1'b0 || yummy_out !== 3'b100) begin
            failures++; $display("FAIL full_end got v=%b y=%b exp v=0 y=100", valid_out, yummy_out);
        end
        cyc();
    endtask

    task automatic test_overflow();
        do_reset();
        ready_out = 1'b0;
        valid_in = 3'b100;
        for (int k = 0; k < 5; k++) begin
            data_in[2*DW +: DW] = pat(2, 32 + k);
`ifdef ALSAQR_CTV_OVF_DETECT_EN
            @(negedge clk);
            checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_early%0d got %b exp 0", k, ovf_err); end
`endif
            cyc();
        end
        valid_in = '0;
`ifdef ALSAQR_CTV_OVF_DETECT_EN
        @(negedge clk);
        checks++; if (ovf_err !== 1'b1 || ovf_ch !== 2'd2) begin
            failures++; $display("FAIL ovf_flag got err=%b ch=%0d exp err=1 ch=2", ovf_err, ovf_ch);
        end
`endif
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (valid_out !== 1'b1 || ch_out !== 2'd2 || data_out !== pat(2, 32 + i)) begin
                failures++; $display("FAIL ovf_flit%0d got v=%b ch=%0d d=%h exp v=1 ch=2 d=%h", i, valid_out, ch_out, data_out, pat(2, 32 + i));
            end
            cyc();
        end
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL ovf_dropped got %b exp 0", valid_out); end
`ifdef ALSAQR_CTV_OVF_DETECT_EN
        checks++; if (ovf_err !== 1'b1 || ovf_ch !== 2'd2) begin
            failures++; $display("FAIL ovf_sticky got err=%b ch=%0d exp err=1 ch=2", ovf_err, ovf_ch);
        end
`endif
        cyc();
    endtask

    task automatic test_reset_mid();
        ready_out = 1'b0;
        valid_in = 3'b001;
        for (int k = 0; k < 3; k++) begin
            data_in[0 +: DW] = pat(0, 48 + k);
            cyc();
        end
        valid_in = '0;
        @(negedge clk);
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got %b exp 1", valid_out); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0 || data_out !== 64'h0 || ch_out !== 2'd0) begin
            failures++; $display("FAIL mid_async got v=%b d=%h ch=%0d exp v=0 d=0 ch=0", valid_out, data_out, ch_out);
        end
        cyc();
        cyc();
        reset = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (yummy_out !== 3'b000 || valid_out !== 1'b0) begin
                failures++; $display("FAIL mid_idle%0d got y=%b v=%b exp y=000 v=0", i, yummy_out, valid_out);
            end
            cyc();
        end
        valid_in = 3'b010;
        data_in[DW +: DW] = 64'hDEAD_BEEF_0000_0042;
        cyc();
        valid_in = '0;
        @(negedge clk);
        checks++; if (valid_out !== 1'b1 || ch_out !== 2'd1 || data_out !== 64'hDEAD_BEEF_0000_0042) begin
            failures++; $display("FAIL mid_new got v=%b ch=%0d d=%h exp v=1 ch=1 d=deadbeef00000042", valid_out, ch_out, data_out);
        end
        cyc();
        @(negedge clk);
        checks++; if (yummy_out !== 3'b010) begin failures++; $display("FAIL mid_new_yummy got %b exp 010", yummy_out); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_full_boundary();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
